gestor_solicitudes_ascensor: RTL and testbench
==============================================

Name: gestor_solicitudes_ascensor

Overview:
- Parametrised successor to the single-instruction button memory.
- Holds every pending floor call as a bitmask, not one latest button.
- Chooses the next target floor with a SCAN (elevator) policy, using the current floor and the travel direction.
- Sits between the button/floor inputs and the elevator motion state machine, which consumes `destino`/`direccion`.

Parameters:
- N_PISOS, 4, number of floors served; legal range 2..16.
- PISO_W, $clog2(N_PISOS) (min 1), width of floor indices.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- piso  input  PISO_W  current floor from the position sensor.
- boton  input  N_PISOS  call buttons; bit i = request floor i; several bits may be high in one cycle; level-sampled every cycle.
- llegada  input  1  one-cycle pulse: car stopped, doors opened at `piso`; clears that floor's request.
- destino  output  PISO_W  next target floor (registered).
- destino_valido  output  1  high when `destino` refers to a pending request.
- direccion  output  2  00 idle, 01 up, 10 down; 11 never driven.
- pendientes  output  N_PISOS  registered pending-request mask.

Behaviour:
- Reset (async assert, sync-released by the system):
  - pend=0, estado=REPOSO, destino=0, destino_valido=0, direccion=00.
  - Reset mid-travel discards all pending calls immediately.
- Request register, per rising edge: pend <= (pend | boton) & ~clr.
  - clr = onehot(piso) when llegada=1 and piso<N_PISOS; otherwise clr=0.
  - Clear wins: boton bit for the current floor asserted in the same cycle as llegada is not stored.
  - pendientes = pend.
- Combinational helpers, all from registered pend and current piso:
  - arriba = any pend bit > piso.
  - abajo = any pend bit < piso.
  - aqui = pend[piso].
  - sup_min = lowest pending index > piso.
  - inf_max = highest pending index < piso.
  - If piso>=N_PISOS: arriba=abajo=aqui=0; FSM holds its state and outputs hold.
- FSM estado in {REPOSO, SUBE, BAJA}, registered:
  - REPOSO:
    - aqui -> stay in REPOSO; destino=piso, valid=1.
    - else arriba&abajo -> go to whichever is nearer (sup_min-piso vs piso-inf_max); tie goes to SUBE.
    - else arriba -> SUBE.
    - else abajo -> BAJA.
    - else stay; valid=0.
  - SUBE:
    - arriba -> stay.
    - else abajo -> BAJA.
    - else -> REPOSO.
    - aqui never reverses direction.
  - BAJA: mirror image of SUBE.
- Outputs, registered from the next-state decision:
  - SUBE: destino=sup_min, direccion=01.
  - BAJA: destino=inf_max, direccion=10.
  - REPOSO: direccion=00; destino=piso if aqui, else destino holds its last value with valid=0.
  - destino_valido = (next estado != REPOSO) | aqui.
- Latency:
  - boton edge at cycle t -> pendientes updated after edge t+1 -> destino/direccion updated after edge t+2.
  - llegada behaves the same way: the clear is visible 1 cycle later, the new target 2 cycles later.
- Floor arithmetic: unsigned, PISO_W bits; distances are computed in PISO_W+1 bits so there is no wrap.
- A request for the current floor while moving (aqui) stays pending until llegada.

Decomposition:
- Shared package `ascensor_pkg`:
  - estado enum {REPOSO, SUBE, BAJA}.
  - direccion encodings DIR_IDLE=2'b00, DIR_UP=2'b01, DIR_DOWN=2'b10.
  - Default N_PISOS.
- One sub-module: `buscador_piso`.
  - Combinational, parametrised by N_PISOS.
  - Inputs: pend, piso.
  - Outputs: arriba, abajo, aqui, sup_min, inf_max.
  - Implemented as priority encoders over masked pend.
  - Instantiated once.

Test Plan:
1. Assert rst_n=0 mid-operation with pend=1010 and estado=SUBE -> same cycle: pendientes=0000, direccion=00, destino_valido=0; all outputs stay 0 with no input activity.
2. N_PISOS=4, piso=0, boton=1000 for one cycle at t -> pendientes=1000 after t+1; direccion=01, destino=3, valid=1 after t+2.
3. piso=1, estado=SUBE, pend=1001 -> destino=3, direccion=01. Then piso=3 with llegada pulse -> pend=0001, next cycle direccion=10, destino=0. Then piso=0 with llegada -> pend=0000, REPOSO, valid=0.
4. REPOSO ties, piso=1:
   - pend=0101 (distance 1 both ways) -> SUBE, destino=2.
   - pend=1001 (up 2, down 1) -> BAJA, destino=0.
5. piso=2, llegada=1 and boton=0100 in the same cycle with pend=0100 -> pend=0000 (clear wins), REPOSO, valid=0.
6. estado=SUBE at piso=2 with pend=0100 only -> no reversal; direccion changes to 00 with destino=2, valid=1 (aqui); after llegada, valid=0.

Source files
------------

// File: rtl/ascensor_pkg.sv
// ascensor_pkg: shared state, direction encodings and default floor count for the elevator request manager.
package ascensor_pkg;
  typedef enum logic [1:0] {REPOSO = 2'd0, SUBE = 2'd1, BAJA = 2'd2} estado_t;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam int N_PISOS_DEF = 4;
endpackage

// File: rtl/buscador_piso.sv
// buscador_piso: priority encoders locating the nearest pending floor above and below the car.
module buscador_piso #(
  parameter int N_PISOS = 4,
  parameter int PISO_W = 2
) (
  input  logic [N_PISOS-1:0] i_pend,
  input  logic [PISO_W-1:0]  i_piso,
  output logic               o_arriba,
  output logic               o_abajo,
  output logic               o_aqui,
  output logic [PISO_W-1:0]  o_sup_min,
  output logic [PISO_W-1:0]  o_inf_max
);
  logic w_ok;
  assign w_ok = int'(i_piso) < N_PISOS;
  always_comb begin
    o_arriba = 1'b0;
    o_abajo = 1'b0;
    o_aqui = 1'b0;
    o_sup_min = '0;
    o_inf_max = '0;
    // Downward scan for the upper search so the last hit is the lowest index, upward scan for the mirror case.
    for (int i = N_PISOS - 1; i >= 0; i--)
      if (w_ok && i_pend[i] && i > int'(i_piso)) begin
        o_arriba = 1'b1;
        o_sup_min = PISO_W'(i);
      end
    for (int i = 0; i < N_PISOS; i++) begin
      if (w_ok && i_pend[i] && i < int'(i_piso)) begin
        o_abajo = 1'b1;
        o_inf_max = PISO_W'(i);
      end
      if (w_ok && i_pend[i] && i == int'(i_piso)) o_aqui = 1'b1;
    end
  end
endmodule

// File: rtl/gestor_solicitudes_ascensor.sv
// gestor_solicitudes_ascensor: pending-call bitmask with SCAN target selection for the elevator motion FSM.
module gestor_solicitudes_ascensor
  import ascensor_pkg::*;
#(
  parameter int N_PISOS = N_PISOS_DEF,
  parameter int PISO_W = (N_PISOS > 2) ? $clog2(N_PISOS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PISO_W-1:0]  piso,
  input  logic [N_PISOS-1:0] boton,
  input  logic               llegada,
  output logic [PISO_W-1:0]  destino,
  output logic               destino_valido,
  output logic [1:0]         direccion,
  output logic [N_PISOS-1:0] pendientes
);
  estado_t r_estado, w_sig;
  logic [N_PISOS-1:0] r_pend, w_clr;
  logic [PISO_W-1:0] r_destino, w_sup_min, w_inf_max;
  logic [PISO_W:0] w_d_sub, w_d_baj;
  logic [1:0] r_dir;
  logic r_valido, w_arriba, w_abajo, w_aqui, w_piso_ok;
  buscador_piso #(.N_PISOS(N_PISOS), .PISO_W(PISO_W)) u_buscador (
    .i_pend(r_pend),
    .i_piso(piso),
    .o_arriba(w_arriba),
    .o_abajo(w_abajo),
    .o_aqui(w_aqui),
    .o_sup_min(w_sup_min),
    .o_inf_max(w_inf_max)
  );
  assign w_piso_ok = {1'b0, piso} < (PISO_W + 1)'(N_PISOS);
  assign w_clr = (llegada && w_piso_ok) ? N_PISOS'(1) << piso : '0;
  assign w_d_sub = {1'b0, w_sup_min} - {1'b0, piso};
  assign w_d_baj = {1'b0, piso} - {1'b0, w_inf_max};
  always_comb begin
    w_sig = r_estado;
    if (w_piso_ok)
      case (r_estado)
        SUBE: w_sig = w_arriba ? SUBE : w_abajo ? BAJA : REPOSO;
        BAJA: w_sig = w_abajo ? BAJA : w_arriba ? SUBE : REPOSO;
        default: w_sig = w_aqui ? REPOSO :
                         (w_arriba && w_abajo) ? ((w_d_sub <= w_d_baj) ? SUBE : BAJA) :
                         w_arriba ? SUBE : w_abajo ? BAJA : REPOSO;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_estado <= REPOSO;
      r_destino <= '0;
      r_valido <= 1'b0;
      r_dir <= DIR_IDLE;
    end else begin
      r_pend <= (r_pend | boton) & ~w_clr;
      // An out-of-range floor reading freezes the decision until the sensor recovers.
      if (w_piso_ok) begin
        r_estado <= w_sig;
        r_destino <= (w_sig == SUBE) ? w_sup_min : (w_sig == BAJA) ? w_inf_max : w_aqui ? piso : r_destino;
        r_valido <= (w_sig != REPOSO) || w_aqui;
        r_dir <= (w_sig == SUBE) ? DIR_UP : (w_sig == BAJA) ? DIR_DOWN : DIR_IDLE;
      end
    end
  end
  assign destino = r_destino;
  assign destino_valido = r_valido;
  assign direccion = r_dir;
  assign pendientes = r_pend;
endmodule

// File: tb/tb_gestor_solicitudes_ascensor.sv
// tb_gestor_solicitudes_ascensor: directed scenarios plus random traffic against a floor-scanning reference model.
module tb_gestor_solicitudes_ascensor;
  localparam int NP = 5;
  localparam int PW = 3;
  logic clk, rst_n, llegada, destino_valido;
  logic [PW-1:0] piso, destino;
  logic [NP-1:0] boton, pendientes;
  logic [1:0] direccion;
  int n_vec = 0, n_err = 0;
  logic [NP-1:0] m_pend;
  int m_dir, m_dest;
  bit m_val;
  gestor_solicitudes_ascensor #(.N_PISOS(NP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .piso(piso),
    .boton(boton),
    .llegada(llegada),
    .destino(destino),
    .destino_valido(destino_valido),
    .direccion(direccion),
    .pendientes(pendientes)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: one edge of the manager, described as "look for the nearest call each way and pick a direction".
  task automatic modelo(input int p, input logic [NP-1:0] b, input bit l);
    int su, ib, nd;
    bit here;
    su = -1;
    ib = -1;
    here = 0;
    if (p < NP) begin
      for (int f = NP - 1; f > p; f--) if (m_pend[f]) su = f;
      for (int f = 0; f < p; f++) if (m_pend[f]) ib = f;
      here = m_pend[p];
      if (m_dir == 1) nd = (su >= 0) ? 1 : (ib >= 0) ? -1 : 0;
      else if (m_dir == -1) nd = (ib >= 0) ? -1 : (su >= 0) ? 1 : 0;
      else if (here) nd = 0;
      else if (su >= 0 && ib >= 0) nd = (su - p <= p - ib) ? 1 : -1;
      else nd = (su >= 0) ? 1 : (ib >= 0) ? -1 : 0;
      m_dest = (nd == 1) ? su : (nd == -1) ? ib : here ? p : m_dest;
      m_val = (nd != 0) || here;
      m_dir = nd;
    end
    m_pend = m_pend | b;
    if (l && p < NP) m_pend[p] = 1'b0;
  endtask
  task automatic comparar();
    chk("pend", 32'(pendientes), 32'(m_pend));
    chk("dest", 32'(destino), 32'(m_dest));
    chk("valid", 32'(destino_valido), 32'(m_val));
    chk("dir", 32'(direccion), (m_dir == 1) ? 32'd1 : (m_dir == -1) ? 32'd2 : 32'd0);
  endtask
  task automatic paso(input int p, input logic [NP-1:0] b, input bit l);
    piso = PW'(p);
    boton = b;
    llegada = l;
    @(posedge clk);
    modelo(p, b, l);
    @(negedge clk);
    comparar();
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    boton = '0;
    llegada = 1'b0;
    #1;
    m_pend = '0;
    m_dir = 0;
    m_dest = 0;
    m_val = 0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_pend", 32'(pendientes), 32'd0);
      chk("rst_dir", 32'(direccion), 32'd0);
      chk("rst_valid", 32'(destino_valido), 32'd0);
      chk("rst_dest", 32'(destino), 32'd0);
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask
  initial begin
    int cur;
    rst_n = 1'b0;
    piso = '0;
    boton = '0;
    llegada = 1'b0;
    @(negedge clk);
    do_reset();
    paso(0, 5'b01010, 0);
    paso(0, 5'b00000, 0);
    chk("t1_pre_dir", 32'(direccion), 32'd1);
    do_reset();
    paso(0, 5'b01000, 0);
    chk("t2_pend", 32'(pendientes), 32'b01000);
    paso(0, 5'b00000, 0);
    chk("t2_dest", 32'(destino), 32'd3);
    chk("t2_dir", 32'(direccion), 32'd1);
    paso(1, 5'b00001, 0);
    paso(1, 5'b00000, 0);
    chk("t3_dest", 32'(destino), 32'd3);
    paso(2, 5'b00000, 0);
    paso(3, 5'b00000, 1);
    chk("t3_pend", 32'(pendientes), 32'b00001);
    paso(3, 5'b00000, 0);
    chk("t3_dir_down", 32'(direccion), 32'd2);
    chk("t3_dest0", 32'(destino), 32'd0);
    paso(0, 5'b00000, 1);
    paso(0, 5'b00000, 0);
    chk("t3_idle", 32'(destino_valido), 32'd0);
    do_reset();
    paso(1, 5'b00101, 0);
    paso(1, 5'b00000, 0);
    chk("t4_tie_dir", 32'(direccion), 32'd1);
    chk("t4_tie_dest", 32'(destino), 32'd2);
    do_reset();
    paso(1, 5'b01001, 0);
    paso(1, 5'b00000, 0);
    chk("t4_near_dir", 32'(direccion), 32'd2);
    do_reset();
    paso(0, 5'b00100, 0);
    paso(2, 5'b00100, 1);
    chk("t5_clear", 32'(pendientes), 32'd0);
    paso(2, 5'b00000, 0);
    chk("t5_valid", 32'(destino_valido), 32'd0);
    do_reset();
    paso(0, 5'b00100, 0);
    paso(1, 5'b00000, 0);
    paso(2, 5'b00000, 0);
    chk("t6_dir", 32'(direccion), 32'd0);
    chk("t6_valid", 32'(destino_valido), 32'd1);
    paso(2, 5'b00000, 1);
    paso(2, 5'b00000, 0);
    chk("t6_after", 32'(destino_valido), 32'd0);
    paso(6, 5'b00010, 1);
    paso(7, 5'b00000, 1);
    paso(4, 5'b00000, 0);
    cur = 2;
    for (int n = 0; n < 600; n++) begin
      cur = cur + int'($urandom_range(0, 2)) - 1;
      cur = (cur < 0) ? 0 : (cur > 7) ? 7 : cur;
      paso(cur, ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 149) == 0) do_reset();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
